point_dispatcher: RTL

Initiator side of the point generator's start/ready handshake. Scans a frame in raster order and issues one start per pixel with x/y coordinates. Waits for the generator's ready, saturates the returned iteration count to framebuffer width, then writes it to the framebuffer with an ack handshake. Sits between the frame controller (frame_go/frame_done) and the generator/framebuffer pair.

---
 rtl/mandel_pkg.sv | 23 ++
 rtl/point_dispatcher_if.sv | 34 +++
 rtl/raster_counter.sv | 45 ++++
 rtl/point_dispatcher.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared states, frame defaults and saturation helper
package mandel_pkg;

  localparam int DEF_H_RES  = 640;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_DATA_W = 8;
  localparam int XY_W       = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } disp_state_t;

  // Largest value a data_w-bit pixel can hold; iterations at or above it clip.
  function automatic logic [63:0] sat_max(input int data_w);
    return (64'd1 << data_w) - 64'd1;
  endfunction

endpackage

// File: rtl/point_dispatcher_if.sv
// rtl/point_dispatcher_if.sv - frame control, generator and framebuffer signals
interface point_dispatcher_if
  import mandel_pkg::*;
#(
  parameter int HBI    = 32,
  parameter int ADDR_W = 19,
  parameter int DATA_W = DEF_DATA_W
);
  logic              frame_go;
  logic              busy;
  logic              frame_done;
  logic              gen_start;
  logic [XY_W-1:0]   gen_x;
  logic [XY_W-1:0]   gen_y;
  logic              gen_ready;
  logic [HBI-1:0]    gen_iteration;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              fb_ack;
  logic              timeout_flag;

  modport master (
    input  frame_go, gen_ready, gen_iteration, fb_ack,
    output busy, frame_done, gen_start, gen_x, gen_y,
           fb_we, fb_addr, fb_data, timeout_flag
  );

  modport slave (
    output frame_go, gen_ready, gen_iteration, fb_ack,
    input  busy, frame_done, gen_start, gen_x, gen_y,
           fb_we, fb_addr, fb_data, timeout_flag
  );
endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order x/y/linear-address counters
module raster_counter
  import mandel_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              advance,
  output logic [XY_W-1:0]   x,
  output logic [XY_W-1:0]   y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic x_end;

  assign x_end = (x == XY_W'(H_RES - 1));
  assign last  = x_end && (y == XY_W'(V_RES - 1));

  // Address counts alongside x/y so no y*H_RES multiply is needed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (x_end) begin
        x <= '0;
        y <= y + XY_W'(1);
      end else begin
        x <= x + XY_W'(1);
      end
    end
  end

endmodule

// File: rtl/point_dispatcher.sv
// rtl/point_dispatcher.sv - per-pixel generator start and framebuffer write sequencer (option: DISPATCH_TIMEOUT_EN)
module point_dispatcher
  import mandel_pkg::*;
#(
  parameter int HBI            = 32,
  parameter int H_RES          = DEF_H_RES,
  parameter int V_RES          = DEF_V_RES,
  parameter int ADDR_W         = 19,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic CLK,
  input  logic RST,
  point_dispatcher_if.master bus
);

  localparam logic [HBI-1:0] SAT_LIMIT = HBI'(sat_max(DATA_W));

  disp_state_t       state, state_nx;
  logic              ctr_clear, ctr_advance, ctr_last;
  logic [XY_W-1:0]   x, y;
  logic [ADDR_W-1:0] addr;
  logic              load_data;
  logic [DATA_W-1:0] data_d, data_q;

  raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (ctr_clear),
    .advance (ctr_advance),
    .x       (x),
    .y       (y),
    .addr    (addr),
    .last    (ctr_last)
  );

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             timeout_q;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state plus counter and data-latch strobes.
  always_comb begin
    state_nx    = state;
    ctr_clear   = 1'b0;
    ctr_advance = 1'b0;
    load_data   = 1'b0;
    data_d      = (bus.gen_iteration >= SAT_LIMIT) ? '1 : bus.gen_iteration[DATA_W-1:0];
`ifdef DISPATCH_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.frame_go) begin
          ctr_clear = 1'b1;
          state_nx  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nx = ST_ARM;
      // gen_ready may still be high from the previous pixel here.
      ST_ARM:   state_nx = ST_WAIT;
      ST_WAIT: begin
        if (bus.gen_ready) begin
          load_data = 1'b1;
          state_nx  = ST_WRITE;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          load_data   = 1'b1;
          data_d      = '1;
          timeout_hit = 1'b1;
          state_nx    = ST_WRITE;
        end
`endif
      end
      ST_WRITE: begin
        if (bus.fb_ack) begin
          if (ctr_last) begin
            state_nx = ST_DONE;
          end else begin
            ctr_advance = 1'b1;
            state_nx    = ST_ISSUE;
          end
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Pixel value held from the WAIT exit until the write is acked.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            data_q <= '0;
    else if (load_data) data_q <= data_d;
  end

`ifdef DISPATCH_TIMEOUT_EN
  // Watchdog: zeroed in ARM (the only way into WAIT), counts while waiting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    wait_cnt <= '0;
    else if (state == ST_ARM)   wait_cnt <= '0;
    else if (state == ST_WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Sticky timeout flag, cleared when a new frame is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              timeout_q <= 1'b0;
    else if (ctr_clear)   timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end

  assign bus.timeout_flag = timeout_q;
`else
  // Watchdog limit has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign bus.timeout_flag   = 1'b0;
`endif

  assign bus.busy       = (state != ST_IDLE);
  assign bus.gen_start  = (state == ST_ISSUE);
  assign bus.fb_we      = (state == ST_WRITE);
  assign bus.frame_done = (state == ST_DONE);
  assign bus.gen_x      = x;
  assign bus.gen_y      = y;
  assign bus.fb_addr    = addr;
  assign bus.fb_data    = data_q;

endmodule
